fastica_mul_arbiter: RTL and testbench



---
 rtl/fastica_pkg.sv | 25 ++
 rtl/fastica_mul_arbiter_if.sv | 35 +++
 rtl/fastica_rr_pick.sv | 35 +++
 rtl/fastica_mul_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fastica_mul_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fastica_pkg.sv
// rtl/fastica_pkg.sv - shared constants, requester ids, FSM state and tag types for the mul1 arbiter
package fastica_pkg;

    localparam int NREQ      = 3;
    localparam int W         = 16;
    localparam int MAX_BURST = 128;
    localparam int MUL_LAT   = 3;
    localparam int LW        = $clog2(MAX_BURST);

    localparam int REQ_SYMM  = 0;
    localparam int REQ_FAST  = 1;
    localparam int REQ_ERROR = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic            valid;
        logic [NREQ-1:0] owner;
        logic            last;
    } tag_t;

endpackage

// File: rtl/fastica_mul_arbiter_if.sv
// rtl/fastica_mul_arbiter_if.sv - requester, multiplier and response signals of the mul1 arbiter
interface fastica_mul_arbiter_if #(
    parameter int NREQ = fastica_pkg::NREQ,
    parameter int W    = fastica_pkg::W,
    parameter int LW   = fastica_pkg::LW
);

    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] burst_len;
    logic [NREQ-1:0]    op_valid;
    logic [NREQ*W-1:0]  op_a;
    logic [NREQ*W-1:0]  op_b;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    op_ready;
    logic               mul_en;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic [2*W-1:0]     mul_p;
    logic [NREQ-1:0]    rsp_valid;
    logic [2*W-1:0]     rsp_data;
    logic               rsp_last;
    logic               busy;

    // master: sub-units plus the mul1 datapath; slave: the arbiter
    modport master (
        output req, burst_len, op_valid, op_a, op_b, mul_p,
        input  gnt, op_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_data, rsp_last, busy
    );

    modport slave (
        input  req, burst_len, op_valid, op_a, op_b, mul_p,
        output gnt, op_ready, mul_en, mul_a, mul_b, rsp_valid, rsp_data, rsp_last, busy
    );

endinterface

// File: rtl/fastica_rr_pick.sv
// rtl/fastica_rr_pick.sv - combinational round-robin picker, first requester at or after ptr wins
module fastica_rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fastica_mul_arbiter.sv
// rtl/fastica_mul_arbiter.sv - shares mul1 between FastICA sub-units, whole bursts granted round-robin
module fastica_mul_arbiter #(
    parameter int NREQ      = fastica_pkg::NREQ,
    parameter int W         = fastica_pkg::W,
    parameter int MAX_BURST = fastica_pkg::MAX_BURST,
    parameter int MUL_LAT   = fastica_pkg::MUL_LAT
) (
    input  logic                  clk_fastica,
    input  logic                  rst_fastica,
    fastica_mul_arbiter_if.slave  bus
);

    import fastica_pkg::*;

    localparam int LW = $clog2(MAX_BURST);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mul_a_q, mul_a_d;
    logic [W-1:0]    mul_b_q, mul_b_d;
    tag_t            iss_q, iss_d;
    tag_t            tag_q [MUL_LAT];

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [LW-1:0]   pick_len;
    logic            sel_valid;
    logic            sel_req;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            accept;
    logic            abort;
    logic            last_beat;
    logic            in_flight;

    fastica_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_req   = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        pick_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cur_q == IW'(i)) begin
                sel_valid = bus.op_valid[i];
                sel_req   = bus.req[i];
                sel_a     = bus.op_a[i*W +: W];
                sel_b     = bus.op_b[i*W +: W];
            end
            if (pick_idx == IW'(i)) begin
                pick_len = bus.burst_len[i*LW +: LW];
            end
        end
    end

    assign accept    = (state_q == ST_GRANT) && sel_valid;
    assign abort     = (state_q == ST_GRANT) && !sel_req;
    assign last_beat = accept && (cnt_q == '0);

    always_ff @(posedge clk_fastica or posedge rst_fastica) begin
        if (rst_fastica) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_any) state_d = ST_GRANT;
            ST_GRANT: if (last_beat || abort) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        iss_d   = '0;
        if ((state_q == ST_IDLE) && pick_any) begin
            gnt_d = pick_gnt;
            cur_d = pick_idx;
            cnt_d = pick_len;
            ptr_d = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
        end
        if (accept) begin
            mul_a_d     = sel_a;
            mul_b_d     = sel_b;
            iss_d.valid = 1'b1;
            iss_d.owner = gnt_q;
            iss_d.last  = last_beat;
            // the final beat leaves the counter at zero rather than wrapping
            if (!last_beat) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
        if (state_d == ST_IDLE) begin
            gnt_d = '0;
        end
    end

    always_ff @(posedge clk_fastica or posedge rst_fastica) begin
        if (rst_fastica) begin
            ptr_q   <= '0;
            cur_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            iss_q   <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            iss_q    <= iss_d;
            tag_q[0] <= iss_q;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // the issue register counts as in flight so busy never dips between last beat and its product
    always_comb begin
        in_flight = iss_q.valid;
        for (int k = 0; k < MUL_LAT; k++) begin
            in_flight = in_flight | tag_q[k].valid;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.op_ready  = gnt_q;
    assign bus.mul_en    = iss_q.valid;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = tag_q[MUL_LAT-1].valid ? tag_q[MUL_LAT-1].owner : '0;
    assign bus.rsp_last  = tag_q[MUL_LAT-1].valid & tag_q[MUL_LAT-1].last;
    assign bus.rsp_data  = bus.mul_p;
    assign bus.busy      = (state_q == ST_GRANT) | in_flight;

endmodule

// File: tb/tb_fastica_mul_arbiter.sv
// tb/tb_fastica_mul_arbiter.sv - self-checking bench for fastica_mul_arbiter
module tb_fastica_mul_arbiter;

    import fastica_pkg::*;

    typedef struct {
        int          due;
        int          owner;
        bit          last;
        logic [31:0] prod;
    } rsp_t;

    logic clk;
    logic rst;

    fastica_mul_arbiter_if bus ();

    fastica_mul_arbiter dut (
        .clk_fastica (clk),
        .rst_fastica (rst),
        .bus         (bus)
    );

    logic [2*W-1:0] mul_pipe [MUL_LAT];
    assign bus.mul_p = mul_pipe[MUL_LAT-1];

    always @(posedge clk) begin
        mul_pipe[0] <= $signed(bus.mul_a) * $signed(bus.mul_b);
        for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit fixed_ops = 0;

    bit              m_grant;
    int              m_owner;
    int              m_rem;
    int              m_ptr;
    logic [NREQ-1:0] exp_gnt;
    bit              exp_en;
    logic [W-1:0]    exp_a;
    logic [W-1:0]    exp_b;
    rsp_t            q [$];

    int          cnt_en, cnt_gnt, cnt_rsp, cnt_last, last_idx, first_acc, first_rsp;
    logic [31:0] first_data;
    int          order [$];
    logic [NREQ-1:0] prev_gnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clr();
        cnt_en = 0; cnt_gnt = 0; cnt_rsp = 0; cnt_last = 0; last_idx = 0;
        first_acc = -1; first_rsp = -1; first_data = '0;
        order.delete();
    endtask

    task automatic model_reset();
        m_grant = 0; m_owner = 0; m_rem = 0; m_ptr = 0;
        exp_gnt = '0; exp_en = 0; exp_a = '0; exp_b = '0;
        q.delete();
    endtask

    task automatic model_step();
        bit acc;
        int w;
        rsp_t r;
        logic signed [W-1:0]   a, b;
        logic signed [2*W-1:0] p;
        exp_en = 0;
        if (!m_grant) begin
            exp_gnt = '0;
            if (bus.req != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_grant = 1;
                m_owner = w;
                m_rem   = int'(bus.burst_len[w*LW +: LW]);
                m_ptr   = (w + 1) % NREQ;
                exp_gnt = NREQ'(1 << w);
            end
        end else begin
            acc = bus.op_valid[m_owner];
            if (acc) begin
                a = bus.op_a[m_owner*W +: W];
                b = bus.op_b[m_owner*W +: W];
                p = a * b;
                exp_en  = 1;
                exp_a   = a;
                exp_b   = b;
                r.due   = cyc + MUL_LAT;
                r.owner = m_owner;
                r.last  = (m_rem == 0);
                r.prod  = p;
                q.push_back(r);
            end
            if ((acc && m_rem == 0) || !bus.req[m_owner]) begin
                m_grant = 0;
                exp_gnt = '0;
            end else if (acc) begin
                m_rem--;
            end
        end
    endtask

    task automatic set_ops();
        if (!fixed_ops) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.op_a[i*W +: W] = W'(cyc * 37 + i * 211 - 900);
                bus.op_b[i*W +: W] = W'(513 - cyc * 19 + i * 7);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            if (!rst) model_step();
            #1;
            set_ops();
        end
    endtask

    task automatic set_len(input int i, input int len);
        bus.burst_len[i*LW +: LW] = LW'(len);
    endtask

    initial begin
        logic [NREQ-1:0] rv;
        bit              busy_e;
        rsp_t            r;
        bit              have;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            rv     = '0;
            have   = 0;
            busy_e = m_grant || (q.size() > 0);
            if (!rst && q.size() > 0 && q[0].due == cyc) begin
                have = 1;
                r    = q.pop_front();
                rv   = NREQ'(1 << r.owner);
            end
            chk("gnt", bus.gnt, exp_gnt);
            chk("op_ready", bus.op_ready, exp_gnt);
            chk("mul_en", bus.mul_en, exp_en);
            if (rst) begin
                chk("mul_a_rst", bus.mul_a, '0);
                chk("mul_b_rst", bus.mul_b, '0);
            end else if (exp_en) begin
                chk("mul_a", bus.mul_a, exp_a);
                chk("mul_b", bus.mul_b, exp_b);
            end
            chk("busy", bus.busy, busy_e);
            chk("rsp_valid", bus.rsp_valid, rv);
            chk("rsp_last", bus.rsp_last, have ? r.last : 1'b0);
            if (have) chk("rsp_data", bus.rsp_data, r.prod);

            if (bus.mul_en) cnt_en++;
            if (bus.gnt != '0) cnt_gnt++;
            if (bus.gnt != '0 && prev_gnt == '0)
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) order.push_back(i);
            if (first_acc < 0 && (bus.gnt & bus.op_valid) != '0) first_acc = cyc;
            if (bus.rsp_valid != '0) begin
                cnt_rsp++;
                if (first_rsp < 0) begin
                    first_rsp  = cyc;
                    first_data = bus.rsp_data;
                end
                if (bus.rsp_last) begin
                    cnt_last++;
                    last_idx = cnt_rsp;
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        rst = 1'b0;
        bus.req = '0; bus.burst_len = '0; bus.op_valid = '0; bus.op_a = '0; bus.op_b = '0;
        model_reset();
        clr();
        #1 rst = 1'b1;
        tick(2);
        chk("reset_gnt", bus.gnt, '0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_mul_en", bus.mul_en, 1'b0);
        chk("reset_rsp_valid", bus.rsp_valid, '0);
        rst = 1'b0;

        // single requester, four beats, fixed operands 300 * -7
        clr();
        fixed_ops = 1;
        bus.op_a[REQ_FAST*W +: W] = 16'sd300;
        bus.op_b[REQ_FAST*W +: W] = -16'sd7;
        bus.req = 3'b010; set_len(REQ_FAST, 3); bus.op_valid = 3'b111;
        tick(5);
        bus.req = '0;
        tick(MUL_LAT + 4);
        fixed_ops = 0;
        chk("t1_mul_en_count", cnt_en, 4);
        chk("t1_rsp_count", cnt_rsp, 4);
        chk("t1_last_count", cnt_last, 1);
        chk("t1_last_on_beat", last_idx, 4);
        chk("t1_gnt_cycles", cnt_gnt, 4);
        chk("t1_rsp_latency", first_rsp - first_acc, 4);
        chk("t1_first_product", first_data, 32'hFFFF_F7CC);
        chk("t1_owner", order.size() == 1 ? order[0] : -1, REQ_FAST);

        // contention from reset: all three asking, two-beat bursts
        rst = 1'b1;
        model_reset();
        bus.req = 3'b111; set_len(0, 1); set_len(1, 1); set_len(2, 1); bus.op_valid = 3'b111;
        tick(2);
        rst = 1'b0;
        clr();
        tick(12);
        bus.req = '0;
        tick(MUL_LAT + 4);
        chk("t2_grants", order.size(), 4);
        if (order.size() == 4) begin
            chk("t2_order0", order[0], 0);
            chk("t2_order1", order[1], 1);
            chk("t2_order2", order[2], 2);
            chk("t2_order3", order[3], 0);
        end
        chk("t2_last_count", cnt_last, 4);
        chk("t2_mul_en_count", cnt_en, 8);

        // bubbles: three beats over a 1,0,0,1,1 valid pattern
        clr();
        bus.req = 3'b010; set_len(REQ_FAST, 2); bus.op_valid = '0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            bus.op_valid = pat[i] ? 3'b010 : 3'b000;
            tick(1);
        end
        bus.req = '0; bus.op_valid = '0;
        tick(MUL_LAT + 4);
        chk("t3_mul_en_count", cnt_en, 3);
        chk("t3_gnt_cycles", cnt_gnt, 5);
        chk("t3_last_count", cnt_last, 1);
        chk("t3_last_on_beat", last_idx, 3);

        // longest burst
        clr();
        bus.req = 3'b100; set_len(REQ_ERROR, MAX_BURST - 1); bus.op_valid = 3'b111;
        tick(MAX_BURST + 1);
        bus.req = '0;
        tick(MUL_LAT + 4);
        chk("t4_mul_en_count", cnt_en, MAX_BURST);
        chk("t4_gnt_cycles", cnt_gnt, MAX_BURST);
        chk("t4_last_count", cnt_last, 1);
        chk("t4_last_on_beat", last_idx, MAX_BURST);

        // abort after two of eight beats, then a normal one-beat burst
        clr();
        bus.req = 3'b100; set_len(REQ_ERROR, 7); bus.op_valid = 3'b111;
        tick(3);
        bus.req = '0; bus.op_valid = '0;
        tick(MUL_LAT + 4);
        chk("t5_mul_en_count", cnt_en, 2);
        chk("t5_rsp_count", cnt_rsp, 2);
        chk("t5_last_count", cnt_last, 0);
        chk("t5_gnt_cycles", cnt_gnt, 3);
        clr();
        bus.req = 3'b001; set_len(REQ_SYMM, 0); bus.op_valid = 3'b111;
        tick(2);
        bus.req = '0;
        tick(MUL_LAT + 4);
        chk("t5_next_owner", order.size() == 1 ? order[0] : -1, REQ_SYMM);
        chk("t5_next_last", cnt_last, 1);
        chk("t5_next_mul_en", cnt_en, 1);

        // reset with three products in flight
        clr();
        bus.req = 3'b010; set_len(REQ_FAST, 7); bus.op_valid = 3'b111;
        tick(4);
        chk("t6_pre_busy", bus.busy, 1'b1);
        chk("t6_pre_rsp", cnt_rsp, 0);
        chk("t6_pre_mul_en", cnt_en, 2);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_gnt", bus.gnt, '0);
        chk("t6_op_ready", bus.op_ready, '0);
        chk("t6_mul_en", bus.mul_en, 1'b0);
        chk("t6_mul_a", bus.mul_a, '0);
        chk("t6_mul_b", bus.mul_b, '0);
        chk("t6_rsp_valid", bus.rsp_valid, '0);
        chk("t6_rsp_last", bus.rsp_last, 1'b0);
        chk("t6_busy", bus.busy, 1'b0);
        bus.req = '0;
        tick(2);
        rst = 1'b0;
        clr();
        tick(12);
        chk("t6_no_rsp_after_reset", cnt_rsp, 0);
        bus.req = 3'b111; set_len(0, 0); set_len(1, 0); set_len(2, 0);
        tick(2);
        bus.req = '0;
        tick(MUL_LAT + 4);
        chk("t6_ptr_zero_winner", order.size() > 0 ? order[0] : -1, 0);
        chk("t6_single_grant", order.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
